// File: rtl/wb_arbiter.sv
// ============================================================================
// Module      : wb_arbiter
// Description : Round-robin, packet-locking writeback arbiter with a
//               single registered output beat (full throughput).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter #(
    parameter int NUM_REQS      = 4,
    parameter int DATAW         = 64,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_REQS-1:0]                        req_valid,
    input  logic [NUM_REQS*DATAW-1:0]                  req_data,
    input  logic [NUM_REQS-1:0]                        req_eop,
    output logic [NUM_REQS-1:0]                        req_ready,
    output logic                                       out_valid,
    output logic [DATAW-1:0]                           out_data,
    output logic                                       out_eop,
    output logic [((NUM_REQS > 1) ? $clog2(NUM_REQS) : 1)-1:0] out_sel,
    input  logic                                       out_ready
);

    localparam int c_SELW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [c_SELW-1:0] r_ptr;
    logic              r_lock;
    logic [c_SELW-1:0] r_lock_idx;
    logic              r_out_valid;
    logic [DATAW-1:0]  r_out_data;
    logic              r_out_eop;
    logic [c_SELW-1:0] r_out_sel;

    logic [c_SELW-1:0] w_rr_grant;
    logic              w_rr_found;
    logic [c_SELW-1:0] w_grant;
    logic              w_grant_valid;
    logic              w_can_accept;
    logic              w_gvalid;
    logic [DATAW-1:0]  w_gdata;
    logic              w_geop;
    logic              w_xfer;
    int                w_dist;
    int                w_best_dist;

    // Distance of requester i from ptr+1 (mod NUM_REQS); the smallest valid one wins.
    always_comb begin
        w_rr_grant  = '0;
        w_rr_found  = 1'b0;
        w_dist      = 0;
        w_best_dist = NUM_REQS;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_dist = i - int'(r_ptr) - 1;
            if (w_dist < 0) w_dist = w_dist + NUM_REQS;
            if (req_valid[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_rr_grant  = c_SELW'(i);
                w_rr_found  = 1'b1;
            end
        end
    end

    assign w_grant       = r_lock ? r_lock_idx : w_rr_grant;
    assign w_grant_valid = r_lock | w_rr_found;
    assign w_can_accept  = ~r_out_valid | out_ready;

    always_comb begin
        w_gvalid  = 1'b0;
        w_gdata   = '0;
        w_geop    = 1'b0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (w_grant == c_SELW'(i)) begin
                w_gvalid = req_valid[i];
                w_gdata  = req_data[i*DATAW +: DATAW];
                w_geop   = req_eop[i];
                if (!reset && w_grant_valid) req_ready[i] = w_can_accept;
            end
        end
    end

    assign w_xfer = w_grant_valid & w_gvalid & w_can_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= c_SELW'(NUM_REQS - 1);
            r_lock      <= 1'b0;
            r_lock_idx  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_eop   <= 1'b0;
            r_out_sel   <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gdata;
                r_out_eop   <= w_geop;
                r_out_sel   <= w_grant;
                if (w_geop) begin
                    r_lock <= 1'b0;
                    r_ptr  <= w_grant;
                end else begin
                    r_lock     <= 1'b1;
                    r_lock_idx <= w_grant;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_eop   = r_out_eop;
    assign out_sel   = r_out_sel;

`ifndef SYNTHESIS
    logic [31:0] r_lock_cnt;

    always_ff @(posedge clk) begin
        if (reset || !r_lock) r_lock_cnt <= '0;
        else                  r_lock_cnt <= r_lock_cnt + 32'd1;
    end

    a_lock_sel: assert property (@(posedge clk) disable iff (reset)
        !(r_lock && r_out_valid && req_valid[r_lock_idx] && (r_out_sel != r_lock_idx)));

    a_lock_timeout: assert property (@(posedge clk) disable iff (reset)
        r_lock_cnt <= STALL_TIMEOUT);
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed self-checking bench for wb_arbiter (4- and 3-way).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_out_ready, a_out_valid, a_out_eop;
    logic [3:0]  a_req_valid, a_req_eop, a_req_ready;
    logic [63:0] a_req_data;
    logic [15:0] a_out_data;
    logic [1:0]  a_out_sel;

    logic        b_reset, b_out_ready, b_out_valid, b_out_eop;
    logic [2:0]  b_req_valid, b_req_eop, b_req_ready;
    logic [23:0] b_req_data;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_sel;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_arbiter #(.NUM_REQS(4), .DATAW(16)) u_dut_a (
        .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_data(a_req_data),
        .req_eop(a_req_eop), .req_ready(a_req_ready), .out_valid(a_out_valid),
        .out_data(a_out_data), .out_eop(a_out_eop), .out_sel(a_out_sel),
        .out_ready(a_out_ready)
    );

    wb_arbiter #(.NUM_REQS(3), .DATAW(8)) u_dut_b (
        .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_data(b_req_data),
        .req_eop(b_req_eop), .req_ready(b_req_ready), .out_valid(b_out_valid),
        .out_data(b_out_data), .out_eop(b_out_eop), .out_sel(b_out_sel),
        .out_ready(b_out_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        a_reset = 1'b1; b_reset = 1'b1;
        a_req_valid = 4'b1111; a_req_eop = 4'b1111; a_out_ready = 1'b1;
        tick(); tick();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", a_out_valid); end
        n_cmp++; if (a_out_eop !== 1'b0) begin n_fail++; $display("FAIL rst_eop: got %b expected 0", a_out_eop); end
        n_cmp++; if (a_out_sel !== 2'd0) begin n_fail++; $display("FAIL rst_sel: got %0d expected 0", a_out_sel); end
        n_cmp++; if (a_out_data !== 16'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 0000", a_out_data); end
        n_cmp++; if (a_req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b expected 0000", a_req_ready); end
        n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid: got %b expected 0", b_out_valid); end
        a_req_valid = 4'b0000;
        a_reset = 1'b0; b_reset = 1'b0;
    endtask

    task automatic test_round_robin;
        logic [1:0] e;
        a_req_data  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        a_req_eop   = 4'b1111;
        a_out_ready = 1'b1;
        a_req_valid = 4'b1111;
        #1;
        n_cmp++; if (a_req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_ready0: got %b expected 0001", a_req_ready); end
        for (int k = 0; k < 5; k++) begin
            tick();
            e = 2'(k % 4);
            n_cmp++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b expected 1", k, a_out_valid); end
            n_cmp++; if (a_out_sel !== e) begin n_fail++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", k, a_out_sel, e); end
            n_cmp++; if (a_out_data !== (16'hA000 + 16'(e))) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", k, a_out_data, 16'hA000 + 16'(e)); end
        end
        a_req_valid = 4'b0000;
        tick();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %b expected 0", a_out_valid); end
    endtask

    task automatic test_packet_lock;
        a_req_valid = 4'b0100; a_req_eop = 4'b0000; a_req_data[47:32] = 16'hB000;
        #1;
        n_cmp++; if (a_req_ready !== 4'b0100) begin n_fail++; $display("FAIL pkt_ready_b1: got %b expected 0100", a_req_ready); end
        tick();
        n_cmp++; if (a_out_sel !== 2'd2 || a_out_eop !== 1'b0 || a_out_data !== 16'hB000) begin n_fail++; $display("FAIL pkt_beat1: got sel %0d eop %b data %h expected sel 2 eop 0 data b000", a_out_sel, a_out_eop, a_out_data); end
        a_req_valid = 4'b0111; a_req_data[47:32] = 16'hB001;
        #1;
        n_cmp++; if (a_req_ready !== 4'b0100) begin n_fail++; $display("FAIL pkt_ready_b2: got %b expected 0100", a_req_ready); end
        tick();
        n_cmp++; if (a_out_sel !== 2'd2 || a_out_eop !== 1'b0 || a_out_data !== 16'hB001) begin n_fail++; $display("FAIL pkt_beat2: got sel %0d eop %b data %h expected sel 2 eop 0 data b001", a_out_sel, a_out_eop, a_out_data); end
        a_req_eop = 4'b0111; a_req_data[47:32] = 16'hB002;
        #1;
        n_cmp++; if (a_req_ready !== 4'b0100) begin n_fail++; $display("FAIL pkt_ready_b3: got %b expected 0100", a_req_ready); end
        tick();
        n_cmp++; if (a_out_sel !== 2'd2 || a_out_eop !== 1'b1 || a_out_data !== 16'hB002) begin n_fail++; $display("FAIL pkt_beat3: got sel %0d eop %b data %h expected sel 2 eop 1 data b002", a_out_sel, a_out_eop, a_out_data); end
        a_req_valid = 4'b0011;
        #1;
        n_cmp++; if (a_req_ready !== 4'b0001) begin n_fail++; $display("FAIL pkt_ready_after: got %b expected 0001", a_req_ready); end
        tick();
        n_cmp++; if (a_out_sel !== 2'd0 || a_out_data !== 16'hA000) begin n_fail++; $display("FAIL pkt_after: got sel %0d data %h expected sel 0 data a000", a_out_sel, a_out_data); end
        a_req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure;
        a_req_valid = 4'b0010; a_req_eop = 4'b1111; a_req_data[31:16] = 16'hC001; a_out_ready = 1'b0;
        #1;
        n_cmp++; if (a_req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_ready_first: got %b expected 0010", a_req_ready); end
        tick();
        a_req_data[31:16] = 16'hC002;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++; if (a_req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready_stall[%0d]: got %b expected 0000", k, a_req_ready); end
            tick();
            n_cmp++; if (a_out_valid !== 1'b1 || a_out_sel !== 2'd1 || a_out_data !== 16'hC001) begin n_fail++; $display("FAIL bp_hold[%0d]: got valid %b sel %0d data %h expected valid 1 sel 1 data c001", k, a_out_valid, a_out_sel, a_out_data); end
        end
        a_out_ready = 1'b1;
        #1;
        n_cmp++; if (a_req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_ready_release: got %b expected 0010", a_req_ready); end
        tick();
        n_cmp++; if (a_out_valid !== 1'b1 || a_out_sel !== 2'd1 || a_out_data !== 16'hC002) begin n_fail++; $display("FAIL bp_next: got valid %b sel %0d data %h expected valid 1 sel 1 data c002", a_out_valid, a_out_sel, a_out_data); end
        a_req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_lock_gap;
        a_req_valid = 4'b1000; a_req_eop = 4'b0001; a_req_data[63:48] = 16'hE000; a_out_ready = 1'b1;
        #1;
        n_cmp++; if (a_req_ready !== 4'b1000) begin n_fail++; $display("FAIL gap_ready_first: got %b expected 1000", a_req_ready); end
        tick();
        n_cmp++; if (a_out_sel !== 2'd3 || a_out_data !== 16'hE000) begin n_fail++; $display("FAIL gap_beat1: got sel %0d data %h expected sel 3 data e000", a_out_sel, a_out_data); end
        a_req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (a_req_ready !== 4'b1000) begin n_fail++; $display("FAIL gap_ready[%0d]: got %b expected 1000", k, a_req_ready); end
            tick();
            n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_idle[%0d]: got valid %b expected 0", k, a_out_valid); end
        end
        a_req_valid = 4'b1001; a_req_eop = 4'b1001; a_req_data[63:48] = 16'hE001;
        #1;
        n_cmp++; if (a_req_ready !== 4'b1000) begin n_fail++; $display("FAIL gap_ready_resume: got %b expected 1000", a_req_ready); end
        tick();
        n_cmp++; if (a_out_sel !== 2'd3 || a_out_eop !== 1'b1 || a_out_data !== 16'hE001) begin n_fail++; $display("FAIL gap_last: got sel %0d eop %b data %h expected sel 3 eop 1 data e001", a_out_sel, a_out_eop, a_out_data); end
        a_req_valid = 4'b0001;
        #1;
        n_cmp++; if (a_req_ready !== 4'b0001) begin n_fail++; $display("FAIL gap_ready_r0: got %b expected 0001", a_req_ready); end
        tick();
        n_cmp++; if (a_out_sel !== 2'd0 || a_out_data !== 16'hA000) begin n_fail++; $display("FAIL gap_r0: got sel %0d data %h expected sel 0 data a000", a_out_sel, a_out_data); end
        a_req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_midpacket;
        a_req_valid = 4'b0010; a_req_eop = 4'b0000; a_req_data[31:16] = 16'hF000; a_out_ready = 1'b0;
        tick();
        n_cmp++; if (a_out_valid !== 1'b1 || a_out_sel !== 2'd1 || a_out_data !== 16'hF000) begin n_fail++; $display("FAIL mr_locked: got valid %b sel %0d data %h expected valid 1 sel 1 data f000", a_out_valid, a_out_sel, a_out_data); end
        a_reset = 1'b1; a_req_valid = 4'b0110; a_req_eop = 4'b1111;
        tick();
        n_cmp++; if (a_out_valid !== 1'b0 || a_out_sel !== 2'd0 || a_out_data !== 16'h0 || a_out_eop !== 1'b0) begin n_fail++; $display("FAIL mr_cleared: got valid %b sel %0d data %h eop %b expected all 0", a_out_valid, a_out_sel, a_out_data, a_out_eop); end
        n_cmp++; if (a_req_ready !== 4'b0000) begin n_fail++; $display("FAIL mr_ready_in_reset: got %b expected 0000", a_req_ready); end
        a_reset = 1'b0; a_out_ready = 1'b1; a_req_data[31:16] = 16'hF001; a_req_data[47:32] = 16'hF002;
        #1;
        n_cmp++; if (a_req_ready !== 4'b0010) begin n_fail++; $display("FAIL mr_ready_first: got %b expected 0010", a_req_ready); end
        tick();
        n_cmp++; if (a_out_sel !== 2'd1 || a_out_data !== 16'hF001) begin n_fail++; $display("FAIL mr_first: got sel %0d data %h expected sel 1 data f001", a_out_sel, a_out_data); end
        tick();
        n_cmp++; if (a_out_sel !== 2'd2 || a_out_data !== 16'hF002) begin n_fail++; $display("FAIL mr_second: got sel %0d data %h expected sel 2 data f002", a_out_sel, a_out_data); end
        a_req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_wrap;
        b_req_data = {8'h22, 8'h11, 8'h00}; b_req_eop = 3'b111; b_out_ready = 1'b1; b_req_valid = 3'b101;
        #1;
        n_cmp++; if (b_req_ready !== 3'b001) begin n_fail++; $display("FAIL wrap_ready0: got %b expected 001", b_req_ready); end
        tick();
        n_cmp++; if (b_out_sel !== 2'd0 || b_out_data !== 8'h00) begin n_fail++; $display("FAIL wrap_g0: got sel %0d data %h expected sel 0 data 00", b_out_sel, b_out_data); end
        n_cmp++; if (b_req_ready !== 3'b100) begin n_fail++; $display("FAIL wrap_ready1: got %b expected 100", b_req_ready); end
        tick();
        n_cmp++; if (b_out_sel !== 2'd2 || b_out_data !== 8'h22) begin n_fail++; $display("FAIL wrap_g1: got sel %0d data %h expected sel 2 data 22", b_out_sel, b_out_data); end
        tick();
        n_cmp++; if (b_out_sel !== 2'd0 || b_out_data !== 8'h00 || b_out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_g2: got sel %0d data %h valid %b expected sel 0 data 00 valid 1", b_out_sel, b_out_data, b_out_valid); end
        b_req_valid = 3'b000;
        tick();
    endtask

    initial begin
        a_reset = 1'b1; a_req_valid = '0; a_req_data = '0; a_req_eop = '0; a_out_ready = 1'b0;
        b_reset = 1'b1; b_req_valid = '0; b_req_data = '0; b_req_eop = '0; b_out_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_lock_gap();
        test_reset_midpacket();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of execution-unit writeback requesters (2..16).
REQ-002 SHALL have parameter DATAW, default 64, payload width per writeback beat.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_REQS  per-requester beat valid.
REQ-006 SHALL have port req_data  input  NUM_REQS*DATAW  per-requester payload; requester i occupies bits [i*DATAW +: DATAW].
REQ-007 SHALL have port req_eop  input  NUM_REQS  per-requester last-beat-of-packet flag.
REQ-008 SHALL have port req_ready  output  NUM_REQS  per-requester beat accepted when high together with req_valid.
REQ-009 SHALL have port out_valid  output  1  writeback beat valid toward the scoreboard and register file.
REQ-010 SHALL have port out_data  output  DATAW  registered payload of the granted beat.
REQ-011 SHALL have port out_eop  output  1  registered eop of the granted beat; scoreboard releases rd only on this.
REQ-012 SHALL have port out_sel  output  max(1,clog2(NUM_REQS))  index of the requester that produced the current output beat.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the output beat.

Function
REQ-014 SHALL hold a round-robin pointer ptr; candidates are searched in order ptr+1, ptr+2, ... modulo NUM_REQS; the first valid one is the grant g.
REQ-015 SHALL hold a lock flag and lock index; while locked, g SHALL equal the lock index regardless of other requests, and no other requester is granted.
REQ-016 SHALL compute can_accept = ~out_valid | out_ready.
REQ-017 SHALL drive req_ready[g] = can_accept only when a grant exists; all other req_ready bits SHALL be 0; req_ready SHALL NOT depend on req_valid of the requester itself except through grant selection.
REQ-018 A transfer SHALL occur when req_valid[g] & req_ready[g]; on transfer the beat (data, eop, g) SHALL be loaded into the output register and out_valid set next cycle (latency exactly 1 cycle).
REQ-019 On transfer with req_eop=0: lock SHALL be set with lock index g; ptr unchanged.
REQ-020 On transfer with req_eop=1: lock SHALL be cleared and ptr SHALL become g, so g has lowest priority next arbitration.
REQ-021 When out_valid & out_ready and no transfer occurs in the same cycle, out_valid SHALL clear next cycle.
REQ-022 Simultaneous out_ready and transfer SHALL replace the output beat with no bubble (full throughput, one beat per cycle).
REQ-023 While out_valid & ~out_ready, out_data, out_eop and out_sel SHALL remain stable.
REQ-024 A locked requester that drops req_valid mid-packet SHALL keep the lock; no other requester is granted until it completes with eop.
REQ-025 With no valid requester and not locked, no req_ready bit SHALL be high and ptr SHALL be unchanged.
REQ-026 Pointer arithmetic SHALL wrap from NUM_REQS-1 to 0; NUM_REQS not a power of two SHALL be supported.
REQ-027 In simulation, an assertion SHALL fire if a locked requester presents valid data with out_sel mismatch, or if the lock persists longer than STALL_TIMEOUT cycles.

Reset
REQ-028 During reset: out_valid=0, out_eop=0, out_sel=0, out_data=0, lock=0, ptr=NUM_REQS-1 (requester 0 has first priority), req_ready=0.
REQ-029 Reset asserted mid-packet SHALL drop the lock and any buffered beat; the next cycle after reset release behaves as power-up.

Verification
REQ-030 NUM_REQS=4, all req_valid=1111, all eop=1, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
REQ-031 Requester 2 sends 3-beat packet (eop on beat 3) while 0 and 1 are valid -> out_sel=2,2,2 then 0; req_ready[0],[1]=0 during the packet.
REQ-032 out_valid=1, out_ready=0 for 5 cycles with req_valid[1]=1 -> out_data/out_sel stable, req_ready=0000; on out_ready=1 the next beat appears one cycle later.
REQ-033 Locked requester 3 deasserts req_valid for 4 cycles mid-packet while requester 0 valid -> no grant to 0; requester 3 resumes and completes, then 0 is granted.
REQ-034 Reset asserted with lock on requester 1 and out_valid=1 -> next cycle out_valid=0, lock=0; with req_valid=0110 first grant after reset is 1.
REQ-035 NUM_REQS=3, ptr=2, req_valid=101 -> grant 0 then 2 then 0, verifying wrap-around.
